// File: rtl/cpu_exc_pkg.sv
// Shared exception/commit definitions: ExcCodes, mem_exc bit positions,
// commit FSM encoding and default exception vectors.
package cpu_exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // mem_exc bit positions; higher index means higher priority
  localparam int EXB_ADEL_I = 6;
  localparam int EXB_RI     = 5;
  localparam int EXB_SYS    = 4;
  localparam int EXB_BP     = 3;
  localparam int EXB_OV     = 2;
  localparam int EXB_ADEL_D = 1;
  localparam int EXB_ADES   = 0;

  localparam logic [31:0] VEC_BEV_DEF  = 32'hBFC0_0380;
  localparam logic [31:0] VEC_NORM_DEF = 32'h8000_0180;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

  typedef enum logic [1:0] {
    BADVA_NONE = 2'd0,
    BADVA_I    = 2'd1,
    BADVA_D    = 2'd2
  } badva_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder for the commit-stage exception vector: picks the
// highest-priority set bit and reports its ExcCode and bad-address source.
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic [6:0] exc_vec,
  output logic       exc_any,
  output logic [4:0] exc_code,
  output badva_sel_e badva_sel
);

  // Fixed-priority selection, bit 6 first
  always_comb begin
    exc_any   = 1'b1;
    exc_code  = EXC_INT;
    badva_sel = BADVA_NONE;
    if (exc_vec[EXB_ADEL_I]) begin
      exc_code  = EXC_ADEL;
      badva_sel = BADVA_I;
    end else if (exc_vec[EXB_RI]) begin
      exc_code = EXC_RI;
    end else if (exc_vec[EXB_SYS]) begin
      exc_code = EXC_SYS;
    end else if (exc_vec[EXB_BP]) begin
      exc_code = EXC_BP;
    end else if (exc_vec[EXB_OV]) begin
      exc_code = EXC_OV;
    end else if (exc_vec[EXB_ADEL_D]) begin
      exc_code  = EXC_ADEL;
      badva_sel = BADVA_D;
    end else if (exc_vec[EXB_ADES]) begin
      exc_code  = EXC_ADES;
      badva_sel = BADVA_D;
    end else begin
      exc_any = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/interrupt/ERET sequencer: strobes CP0, flushes the
// pipeline, holds a fetch redirect and masks interrupts briefly after ERET.
module exc_commit_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] VEC_BEV     = VEC_BEV_DEF,
  parameter logic [31:0] VEC_NORM    = VEC_NORM_DEF,
  parameter int          INT_HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic        mem_eret,
  input  logic [31:0] mem_badva_i,
  input  logic [31:0] mem_badva_d,
  input  logic        int_pending,
  input  logic        sr_bev,
  input  logic [31:0] cp0_epc,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badva,
  output logic        eret_commit,
  output logic        flush,
  output logic        stall,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  localparam logic [3:0] HOLDOFF_LD = INT_HOLDOFF[3:0];

  exc_state_e  state_r, state_nxt_s;
  logic [3:0]  holdoff_r;
  logic [31:0] target_r, target_nxt_s;
  logic        from_eret_r, from_eret_nxt_s;
  logic        enc_any_s;
  logic [4:0]  enc_code_s;
  badva_sel_e  enc_badva_s;
  logic [31:0] vec_s;

  exc_prio_enc u_prio (
    .exc_vec   (mem_exc),
    .exc_any   (enc_any_s),
    .exc_code  (enc_code_s),
    .badva_sel (enc_badva_s)
  );

  assign vec_s = sr_bev ? VEC_BEV : VEC_NORM;

  // Next-state, latched target and combinational commit strobes
  always_comb begin
    state_nxt_s     = state_r;
    target_nxt_s    = target_r;
    from_eret_nxt_s = from_eret_r;
    exc_commit      = 1'b0;
    exc_code        = EXC_INT;
    exc_bd          = 1'b0;
    exc_badva       = 32'd0;
    eret_commit     = 1'b0;
    stall           = 1'b0;
    redir_valid     = 1'b0;
    redir_pc        = target_r;
    exc_epc         = mem_bd ? (mem_pc - 32'd4) : mem_pc;
    case (state_r)
      ST_IDLE: begin
        if (!mem_valid) begin
          state_nxt_s = ST_IDLE;
        end else if (int_pending && (holdoff_r == 4'd0)) begin
          exc_commit      = 1'b1;
          exc_bd          = mem_bd;
          target_nxt_s    = vec_s;
          from_eret_nxt_s = 1'b0;
          state_nxt_s     = ST_REDIR;
        end else if (enc_any_s) begin
          exc_commit      = 1'b1;
          exc_code        = enc_code_s;
          exc_bd          = mem_bd;
          target_nxt_s    = vec_s;
          from_eret_nxt_s = 1'b0;
          state_nxt_s     = ST_REDIR;
          case (enc_badva_s)
            BADVA_I: exc_badva = mem_badva_i;
            BADVA_D: exc_badva = mem_badva_d;
            default: exc_badva = 32'd0;
          endcase
        end else if (mem_eret) begin
          eret_commit     = 1'b1;
          target_nxt_s    = cp0_epc;
          from_eret_nxt_s = 1'b1;
          state_nxt_s     = ST_REDIR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REDIR: begin
        redir_valid = 1'b1;
        stall       = 1'b1;
        if (redir_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REDIR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    flush = exc_commit | eret_commit;
  end

  // FSM state, redirect target and redirect-origin registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      target_r    <= 32'd0;
      from_eret_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      target_r    <= target_nxt_s;
      from_eret_r <= from_eret_nxt_s;
    end
  end

  // Post-ERET interrupt holdoff, armed at the ERET redirect handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      holdoff_r <= 4'd0;
    end else if ((state_r == ST_REDIR) && redir_ready && from_eret_r) begin
      holdoff_r <= HOLDOFF_LD;
    end else if (holdoff_r != 4'd0) begin
      holdoff_r <= holdoff_r - 4'd1;
    end else begin
      holdoff_r <= 4'd0;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the commit controller.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VB = 32'hBFC0_0380;
  localparam logic [31:0] VN = 32'h8000_0180;
  localparam int          HO = 2;

  logic        clk = 1'b0;
  logic        resetn, mem_valid, mem_bd, mem_eret, int_pending, sr_bev, redir_ready;
  logic [31:0] mem_pc, mem_badva_i, mem_badva_d, cp0_epc;
  logic [6:0]  mem_exc;
  logic        exc_commit, exc_bd, eret_commit, flush, stall, redir_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badva, redir_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_redir = 1'b0;
  bit          m_from_eret = 1'b0;
  logic [31:0] m_tgt = 32'd0;
  int          m_hold = 0;
  int unsigned code_of [7] = '{5, 4, 12, 9, 8, 10, 4};

  always #5 clk = ~clk;

  exc_commit_ctrl #(.VEC_BEV(VB), .VEC_NORM(VN), .INT_HOLDOFF(HO)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_bd(mem_bd), .mem_exc(mem_exc), .mem_eret(mem_eret),
    .mem_badva_i(mem_badva_i), .mem_badva_d(mem_badva_d),
    .int_pending(int_pending), .sr_bev(sr_bev), .cp0_epc(cp0_epc),
    .exc_commit(exc_commit), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .exc_badva(exc_badva), .eret_commit(eret_commit),
    .flush(flush), .stall(stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance the model
  task automatic cycle();
    logic        e_commit, e_bd, e_eret, event_s;
    logic [4:0]  e_code;
    logic [31:0] e_badva, e_tgt;
    int          top;
    e_commit = 1'b0; e_bd = 1'b0; e_eret = 1'b0; event_s = 1'b0;
    e_code = 5'd0; e_badva = 32'd0; e_tgt = m_tgt;
    @(negedge clk);
    if (!m_redir && mem_valid) begin
      if (int_pending && m_hold == 0) begin
        e_commit = 1'b1; e_bd = mem_bd; e_tgt = sr_bev ? VB : VN; event_s = 1'b1;
      end else if (mem_exc != 7'd0) begin
        top = -1;
        for (int i = 0; i < 7; i++) if (mem_exc[i]) top = i;
        e_commit = 1'b1; e_bd = mem_bd; e_code = 5'(code_of[top]);
        e_badva = (top == 6) ? mem_badva_i : ((top <= 1) ? mem_badva_d : 32'd0);
        e_tgt = sr_bev ? VB : VN; event_s = 1'b1;
      end else if (mem_eret) begin
        e_eret = 1'b1; e_tgt = cp0_epc; event_s = 1'b1;
      end
    end
    chk("exc_commit", 32'(exc_commit), 32'(e_commit));
    chk("exc_code", 32'(exc_code), 32'(e_code));
    chk("exc_epc", exc_epc, mem_bd ? mem_pc - 32'd4 : mem_pc);
    chk("exc_bd", 32'(exc_bd), 32'(e_bd));
    chk("exc_badva", exc_badva, e_badva);
    chk("eret_commit", 32'(eret_commit), 32'(e_eret));
    chk("flush", 32'(flush), 32'(e_commit | e_eret));
    chk("stall", 32'(stall), 32'(m_redir));
    chk("redir_valid", 32'(redir_valid), 32'(m_redir));
    chk("redir_pc", redir_pc, m_tgt);
    @(posedge clk);
    if (!resetn) begin
      m_redir = 1'b0; m_from_eret = 1'b0; m_tgt = 32'd0; m_hold = 0;
    end else begin
      if (m_redir && redir_ready && m_from_eret) m_hold = HO;
      else if (m_hold > 0) m_hold = m_hold - 1;
      if (m_redir) begin
        if (redir_ready) m_redir = 1'b0;
      end else if (event_s) begin
        m_redir = 1'b1; m_tgt = e_tgt; m_from_eret = e_eret;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_pc = 32'h8000_0000; mem_bd = 1'b0; mem_exc = 7'd0;
    mem_eret = 1'b0; mem_badva_i = 32'h0; mem_badva_d = 32'h0; int_pending = 1'b0;
    sr_bev = 1'b0; cp0_epc = 32'h0; redir_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    cycle();
    resetn = 1'b1;
    #2;
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    cycle();

    // Sys, not in a delay slot, BEV=1, redirect held off for 3 cycles
    mem_valid = 1'b1; mem_pc = 32'h8000_1000; mem_exc = 7'b0010000; sr_bev = 1'b1;
    #2;
    chk("sys_code", 32'(exc_code), 32'd8);
    chk("sys_epc", exc_epc, 32'h8000_1000);
    cycle();
    idle_inputs();
    repeat (3) cycle();
    chk("sys_redir_pc", redir_pc, VB);
    redir_ready = 1'b1;
    cycle();
    redir_ready = 1'b0;
    #2;
    chk("sys_back_idle", 32'(redir_valid), 32'd0);
    cycle();

    // AdEL_d + Ov in a delay slot
    mem_valid = 1'b1; mem_pc = 32'h8000_2004; mem_bd = 1'b1; mem_exc = 7'b0000110;
    mem_badva_d = 32'h13;
    #2;
    chk("ov_code", 32'(exc_code), 32'd12);
    chk("ov_epc", exc_epc, 32'h8000_2000);
    chk("ov_badva", exc_badva, 32'd0);
    cycle();
    idle_inputs(); redir_ready = 1'b1;
    cycle();

    // ERET then interrupt pending throughout the holdoff window
    mem_valid = 1'b1; mem_eret = 1'b1; cp0_epc = 32'h8000_3000; redir_ready = 1'b0;
    #2;
    chk("eret_strobe", 32'(eret_commit), 32'd1);
    cycle();
    mem_eret = 1'b0; redir_ready = 1'b1; int_pending = 1'b1;
    #2;
    chk("eret_redir_pc", redir_pc, 32'h8000_3000);
    cycle();
    redir_ready = 1'b0;
    #2; chk("hold_1", 32'(exc_commit), 32'd0); cycle();
    #2; chk("hold_2", 32'(exc_commit), 32'd0); cycle();
    #2; chk("hold_int", 32'(exc_commit), 32'd1); cycle();
    idle_inputs(); redir_ready = 1'b1;
    cycle();

    // ERET with RI: exception wins
    mem_valid = 1'b1; mem_eret = 1'b1; mem_exc = 7'b0100000; sr_bev = 1'b0;
    #2;
    chk("eri_code", 32'(exc_code), 32'd10);
    chk("eri_eret", 32'(eret_commit), 32'd0);
    cycle();
    idle_inputs();
    #2; chk("eri_pc", redir_pc, VN);
    cycle();

    // Reset while redirecting, then a normal exception
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    #2;
    chk("rst_mid_valid", 32'(redir_valid), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    cycle();
    mem_valid = 1'b1; mem_exc = 7'b0001000;
    cycle();
    idle_inputs(); redir_ready = 1'b1;
    cycle();

    // mem_valid low with everything asserted
    mem_exc = 7'h7F; int_pending = 1'b1; mem_eret = 1'b1;
    #2; chk("nv_flush", 32'(flush), 32'd0);
    cycle(); cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      resetn      = ($urandom_range(0, 99) != 0);
      mem_valid   = ($urandom_range(0, 3) != 0);
      mem_pc      = {$urandom()} & 32'hFFFF_FFFC;
      mem_bd      = $urandom_range(0, 1) == 1;
      mem_exc     = ($urandom_range(0, 2) == 0) ? 7'($urandom()) : 7'd0;
      mem_eret    = ($urandom_range(0, 2) == 0);
      mem_badva_i = $urandom();
      mem_badva_d = $urandom();
      int_pending = ($urandom_range(0, 2) == 0);
      sr_bev      = $urandom_range(0, 1) == 1;
      cp0_epc     = $urandom();
      redir_ready = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Sequences exception, interrupt and ERET commit between the pipeline's commit (MEM) stage, the CP0 interrupt unit and the fetch stage. It picks the single highest-priority event for the instruction at commit and strobes the CP0 write controls. It then flushes the pipeline and holds a PC redirect until fetch accepts it. After each ERET it masks interrupts for a programmable number of cycles, so the returned-to instruction always commits once.

## Interface
Parameters:
- VEC_BEV, 32'hBFC00380, exception vector when Status.BEV=1
- VEC_NORM, 32'h80000180, exception vector when Status.BEV=0
- INT_HOLDOFF, 2, cycles after ERET handshake during which int_pending is ignored (0..15)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_valid  in  1  valid instruction at commit stage
- mem_pc  in  32  its PC
- mem_bd  in  1  it sits in a branch delay slot
- mem_exc  in  7  {AdEL_i, RI, Sys, Bp, Ov, AdEL_d, AdES}; bit 6 has highest priority
- mem_eret  in  1  instruction is ERET
- mem_badva_i / mem_badva_d  in  32  fetch / data bad addresses
- int_pending  in  1  enabled, unmasked interrupt reported by CP0
- sr_bev  in  1  Status.BEV
- cp0_epc  in  32  current EPC
- exc_commit  out  1  CP0 exception write strobe
- exc_code  out  5  ExcCode: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12
- exc_epc  out  32  mem_pc-4 if mem_bd, else mem_pc
- exc_bd  out  1  Cause.BD value
- exc_badva  out  32  badva_i for AdEL_i; badva_d for AdEL_d/AdES; else 0
- eret_commit  out  1  CP0 ERET strobe (restores Status)
- flush  out  1  kill IF..MEM
- stall  out  1  freeze fetch/decode
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_ready  in  1  fetch accepts redirect

## Operation
- States: IDLE, REDIR. A holdoff counter (4 bits) runs alongside.
- Event select in IDLE with mem_valid=1, highest priority first:
  - (int_pending & holdoff==0) → interrupt
  - any mem_exc bit → synchronous exception (first set bit)
  - mem_eret → ERET
  - none → no action
- Interrupt and exception events:
  - exc_commit=1, flush=1
  - exc_code, exc_epc, exc_bd and exc_badva driven combinationally in the same cycle
  - target latched = sr_bev ? VEC_BEV : VEC_NORM
  - next state REDIR
- ERET event: eret_commit=1, flush=1, target latched = cp0_epc; next state REDIR.
- REDIR:
  - redir_valid=1, stall=1; redir_pc holds the latched target, stable until the handshake
  - mem_valid, mem_exc, mem_eret and int_pending are ignored
  - redir_valid & redir_ready → IDLE
  - if the redirect came from an ERET, holdoff is loaded with INT_HOLDOFF
- Holdoff decrements by 1 each cycle while nonzero, saturating at 0.
- All strobes are 0 when mem_valid=0.

## Timing
- Reset values:
  - state IDLE, holdoff 0, latched target 0
  - all outputs 0, except exc_epc, which follows mem_pc combinationally
- Decision-to-strobe latency: 0 cycles (combinational from the commit inputs in IDLE). CP0 captures on the same clk edge that enters REDIR.
- redir_valid rises 1 cycle after the strobe and stays high until accepted. Minimum REDIR dwell is 1 cycle (redir_ready already high).
- Boundary rules:
  - ERET together with any mem_exc bit: the exception wins, and eret_commit stays 0.
  - int_pending on the ERET's own commit cycle: the interrupt wins, because holdoff is 0.
  - Holdoff starts counting from the IDLE cycle after the ERET handshake.
  - resetn low in REDIR: the next cycle is IDLE with redir_valid=0, and the latched target is cleared.
  - redir_ready while in IDLE is ignored.

## Structure
- Shared package cpu_exc_pkg holds:
  - ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV)
  - the mem_exc bit-index constants
  - the state encoding
  - VEC_BEV/VEC_NORM defaults
- One sub-module, exc_prio_enc: combinational, takes the 7-bit vector and returns the valid flag, 5-bit code and bad-address select.

## Test plan
- Sys on a non-delay-slot instruction: mem_pc=0x80001000, mem_exc=7'b0010000, sr_bev=1, redir_ready held 0 for 3 cycles.
  - Same cycle: exc_commit=1, exc_code=8, exc_epc=0x80001000, flush=1.
  - Next cycles: redir_valid=1 with redir_pc=0xBFC00380 for 4 cycles, then IDLE.
- AdEL_d together with Ov in a delay slot: mem_pc=0x80002004, mem_bd=1, mem_badva_d=0x13.
  - Required: exc_code=12 (Ov beats AdEL_d), exc_epc=0x80002000, exc_bd=1, exc_badva=0.
- ERET with cp0_epc=0x80003000, INT_HOLDOFF=2, int_pending held 1 after the handshake.
  - Required: eret_commit=1 and redir_pc=0x80003000.
  - An interrupt is not taken in the first 2 IDLE cycles; exc_commit=1 with exc_code=0 on the 3rd.
- ERET and RI on the same commit.
  - Required: exc_code=10, eret_commit=0, redir_pc=VEC_NORM when sr_bev=0.
- Reset mid-REDIR: resetn=0 for 1 cycle.
  - Required: redir_valid=0 and stall=0 afterwards; a later mem_exc is handled normally.
- mem_valid=0 with mem_exc=7'h7F and int_pending=1.
  - Required: no strobes and state stays IDLE.
